// File: rtl/lcd_sync_gen.sv
// LCD capture-path synchroniser: registers the parallel bus, qualifies active pixels,
// produces X/Y coordinates, SOF/EOL strobes, measured geometry and a sticky geometry error.
module lcd_sync_gen #(
  parameter int DATA_W  = 24,
  parameter int COORD_W = 12,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b0,
  parameter bit USE_DE  = 1'b1,
  parameter int H_BP    = 40,
  parameter int H_ACT   = 800,
  parameter int V_BP    = 29,
  parameter int V_ACT   = 480
) (
  input  logic               lcd_pclk_i,
  input  logic               rst,
  input  logic [DATA_W-1:0]  lcd_data_i,
  input  logic               lcd_vsync_i,
  input  logic               lcd_hsync_i,
  input  logic               lcd_de_i,
  input  logic               lcd_err_clr_i,
  output logic               lcd_clk_o,
  output logic [DATA_W-1:0]  lcd_data_o,
  output logic               lcd_data_valid_o,
  output logic [COORD_W-1:0] lcd_x_o,
  output logic [COORD_W-1:0] lcd_y_o,
  output logic               lcd_sof_o,
  output logic               lcd_eol_o,
  output logic [COORD_W-1:0] lcd_width_o,
  output logic [COORD_W-1:0] lcd_height_o,
  output logic               lcd_geom_err_o
);

  typedef enum logic [1:0] {H_IDLE, H_PORCH, H_ACTIVE} h_state_t;
  typedef enum logic [1:0] {V_IDLE, V_PORCH, V_ACTIVE} v_state_t;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  logic hs_q, vs_q, hs_end, vs_end, act;
  logic had_act, first_line, seen_vs, line_end, x_sat, geom_set;
  logic [COORD_W-1:0] x_cnt, y_cnt, x_eff, y_inc, y_eff;

  assign lcd_clk_o = lcd_pclk_i;
  assign hs_end = (hs_q == HS_POL) && (lcd_hsync_i != HS_POL);
  assign vs_end = (vs_q == VS_POL) && (lcd_vsync_i != VS_POL);

  generate
    if (USE_DE) begin : g_de
      assign act = lcd_de_i;
    end else begin : g_timing
      h_state_t    h_state, h_state_n, h_st;
      v_state_t    v_state, v_state_n, v_st;
      logic [15:0] h_cnt, h_cnt_n, h_c, v_cnt, v_cnt_n, v_c;
      logic        unused_de;

      assign unused_de = lcd_de_i;

      always_ff @(posedge lcd_pclk_i) begin
        if (rst) begin
          h_state <= H_IDLE;
          v_state <= V_IDLE;
          h_cnt   <= '0;
          v_cnt   <= '0;
        end else begin
          h_state <= h_state_n;
          v_state <= v_state_n;
          h_cnt   <= h_cnt_n;
          v_cnt   <= v_cnt_n;
        end
      end

      // A sync edge restarts its porch in the same cycle, so H_BP=0 is active on hs_end itself
      always_comb begin
        h_st = h_state;
        h_c  = h_cnt;
        if (hs_end) begin
          h_st = (H_BP == 0) ? H_ACTIVE : H_PORCH;
          h_c  = '0;
        end
        h_state_n = h_st;
        h_cnt_n   = h_c + 16'd1;
        case (h_st)
          H_PORCH:  if (h_c == 16'(H_BP - 1)) begin h_state_n = H_ACTIVE; h_cnt_n = '0; end
          H_ACTIVE: if (h_c == 16'(H_ACT - 1)) begin h_state_n = H_IDLE; h_cnt_n = '0; end
          default:  h_cnt_n = '0;
        endcase

        v_st = v_state;
        v_c  = v_cnt;
        if (vs_end) begin
          v_st = (V_BP == 0) ? V_ACTIVE : V_PORCH;
          v_c  = '0;
        end
        v_state_n = v_st;
        v_cnt_n   = v_c;
        if (hs_end) begin
          case (v_st)
            V_PORCH:  if (v_c + 16'd1 == 16'(V_BP)) begin v_state_n = V_ACTIVE; v_cnt_n = '0; end
                      else v_cnt_n = v_c + 16'd1;
            V_ACTIVE: if (v_c + 16'd1 == 16'(V_ACT)) begin v_state_n = V_IDLE; v_cnt_n = '0; end
                      else v_cnt_n = v_c + 16'd1;
            default:  v_cnt_n = '0;
          endcase
        end
      end

      // The line opened by this cycle's hs_end already belongs to the updated V state
      assign act = (h_st == H_ACTIVE) && (v_state_n == V_ACTIVE);
    end
  endgenerate

  assign x_eff    = hs_end ? '0 : x_cnt;
  assign x_sat    = (x_eff == COORD_MAX);
  assign line_end = hs_end && had_act;
  assign y_inc    = (line_end && (y_cnt != COORD_MAX)) ? y_cnt + 1'b1 : y_cnt;
  assign y_eff    = vs_end ? '0 : y_inc;
  assign geom_set = (act && x_sat) ||
                    (line_end && !first_line && (x_cnt != lcd_width_o));

  always_ff @(posedge lcd_pclk_i) begin
    if (rst) begin
      hs_q             <= 1'b0;
      vs_q             <= 1'b0;
      x_cnt            <= '0;
      y_cnt            <= '0;
      had_act          <= 1'b0;
      first_line       <= 1'b1;
      seen_vs          <= 1'b0;
      lcd_data_o       <= '0;
      lcd_data_valid_o <= 1'b0;
      lcd_x_o          <= '0;
      lcd_y_o          <= '0;
      lcd_sof_o        <= 1'b0;
      lcd_eol_o        <= 1'b0;
      lcd_width_o      <= '0;
      lcd_height_o     <= '0;
      lcd_geom_err_o   <= 1'b0;
    end else begin
      hs_q             <= lcd_hsync_i;
      vs_q             <= lcd_vsync_i;
      lcd_data_valid_o <= act;
      lcd_data_o       <= act ? lcd_data_i : '0;
      lcd_sof_o        <= vs_end;
      lcd_eol_o        <= line_end;
      if (act) begin
        lcd_x_o <= x_eff;
        lcd_y_o <= y_eff;
        x_cnt   <= x_sat ? x_eff : x_eff + 1'b1;
      end else begin
        x_cnt   <= x_eff;
      end
      had_act <= act || (had_act && !hs_end);
      y_cnt   <= y_eff;
      if (line_end) lcd_width_o <= x_cnt;
      // Only a frame that started on an observed vs_end has a trustworthy line count
      if (vs_end) begin
        seen_vs <= 1'b1;
        if (seen_vs) lcd_height_o <= y_inc;
      end
      if (vs_end) first_line <= 1'b1;
      else if (line_end) first_line <= 1'b0;
      if (geom_set) lcd_geom_err_o <= 1'b1;
      else if (lcd_err_clr_i) lcd_geom_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_sync_gen.sv
// Directed bench for lcd_sync_gen: DE mode (A), timing mode (B) and narrow coordinates (C)
// share one LCD stimulus stream; A's pixel stream is checked through an expected queue.
module tb_lcd_sync_gen;

  logic        clk = 1'b0;
  logic        rst, vsync, hsync, de, clr;
  logic [23:0] data;

  logic        clk_a, valid_a, sof_a, eol_a, err_a;
  logic [23:0] data_a;
  logic [11:0] x_a, y_a, width_a, height_a;
  logic        clk_b, valid_b, sof_b, eol_b, err_b;
  logic [23:0] data_b;
  logic [11:0] x_b, y_b, width_b, height_b;
  logic        clk_c, valid_c, sof_c, eol_c, err_c;
  logic [23:0] data_c;
  logic [2:0]  x_c, y_c, width_c, height_c;

  int n_vec = 0;
  int n_err = 0;
  int cyc_idx = 0;
  int eol_cnt = 0;
  bit chk_b = 1'b0;
  bit b_line_act = 1'b0;
  int b_y = 0;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_sync_gen u_a (
    .lcd_pclk_i(clk), .rst(rst), .lcd_data_i(data), .lcd_vsync_i(vsync),
    .lcd_hsync_i(hsync), .lcd_de_i(de), .lcd_err_clr_i(clr), .lcd_clk_o(clk_a),
    .lcd_data_o(data_a), .lcd_data_valid_o(valid_a), .lcd_x_o(x_a), .lcd_y_o(y_a),
    .lcd_sof_o(sof_a), .lcd_eol_o(eol_a), .lcd_width_o(width_a),
    .lcd_height_o(height_a), .lcd_geom_err_o(err_a));

  lcd_sync_gen #(.USE_DE(1'b0), .H_BP(2), .H_ACT(3), .V_BP(1), .V_ACT(2)) u_b (
    .lcd_pclk_i(clk), .rst(rst), .lcd_data_i(data), .lcd_vsync_i(vsync),
    .lcd_hsync_i(hsync), .lcd_de_i(de), .lcd_err_clr_i(clr), .lcd_clk_o(clk_b),
    .lcd_data_o(data_b), .lcd_data_valid_o(valid_b), .lcd_x_o(x_b), .lcd_y_o(y_b),
    .lcd_sof_o(sof_b), .lcd_eol_o(eol_b), .lcd_width_o(width_b),
    .lcd_height_o(height_b), .lcd_geom_err_o(err_b));

  lcd_sync_gen #(.COORD_W(3)) u_c (
    .lcd_pclk_i(clk), .rst(rst), .lcd_data_i(data), .lcd_vsync_i(vsync),
    .lcd_hsync_i(hsync), .lcd_de_i(de), .lcd_err_clr_i(clr), .lcd_clk_o(clk_c),
    .lcd_data_o(data_c), .lcd_data_valid_o(valid_c), .lcd_x_o(x_c), .lcd_y_o(y_c),
    .lcd_sof_o(sof_c), .lcd_eol_o(eol_c), .lcd_width_o(width_c),
    .lcd_height_o(height_c), .lcd_geom_err_o(err_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge reflect the inputs just applied
  task automatic tick();
    logic [47:0] e;
    logic        exp_v;
    @(posedge clk);
    #1;
    if (valid_a) begin
      if (exp_q.size() == 0) check("a_unexpected_pixel", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("a_pixel", {y_a, x_a, data_a}, e);
      end
    end else begin
      check("a_idle_data", data_a, 0);
    end
    if (eol_a) eol_cnt++;
    if (chk_b) begin
      exp_v = b_line_act && (cyc_idx >= 2) && (cyc_idx <= 4);
      check("b_valid", valid_b, exp_v);
      if (exp_v) begin
        check("b_x", x_b, cyc_idx - 2);
        check("b_y", y_b, b_y);
      end
    end
    cyc_idx++;
  endtask

  task automatic blank(input int n);
    de = 1'b0;
    data = '0;
    repeat (n) tick();
  endtask

  // hsync asserted for two cycles; the deassertion cycle is line cycle 0
  task automatic hs_start();
    de = 1'b0;
    data = '0;
    hsync = 1'b1;
    tick();
    tick();
    hsync = 1'b0;
    cyc_idx = 0;
    tick();
    tick();
  endtask

  task automatic pix(input int x, input int y);
    de = 1'b1;
    data = 24'($urandom);
    exp_q.push_back({12'(y), 12'(x), data});
    tick();
  endtask

  task automatic line(input int n, input int y);
    hs_start();
    for (int k = 0; k < n; k++) pix(k, y);
    blank(4);
  endtask

  task automatic vsync_pulse();
    hsync = 1'b0;
    de = 1'b0;
    data = '0;
    vsync = 1'b0;
    tick();
    tick();
    vsync = 1'b1;
    tick();
  endtask

  task automatic rst_check(input string tag);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_data"}, data_a, 0);
    check({tag, "_x"}, x_a, 0);
    check({tag, "_y"}, y_a, 0);
    check({tag, "_sof"}, sof_a, 0);
    check({tag, "_eol"}, eol_a, 0);
    check({tag, "_width"}, width_a, 0);
    check({tag, "_height"}, height_a, 0);
    check({tag, "_err"}, err_a, 0);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0; clr = 1'b0; data = '0;
    repeat (3) tick();
    rst_check("reset");
    check("reset_b_valid", valid_b, 0);
    check("reset_c_err", err_c, 0);
    check("clk_passthrough", clk_a, clk);

    // 4x3 DE frame preceded by 5 blank lines
    rst = 1'b0;
    tick();
    tick();
    vsync = 1'b1;
    tick();
    check("sof_first", sof_a, 1);
    check("height_unseen", height_a, 0);
    tick();
    check("sof_one_cycle", sof_a, 0);
    repeat (5) line(0, 0);
    check("blank_no_eol", eol_cnt, 0);
    for (int y = 0; y < 3; y++) line(4, y);
    hs_start();
    check("frame_eol_count", eol_cnt, 3);
    check("frame_width", width_a, 4);
    vsync_pulse();
    check("frame_sof", sof_a, 1);
    check("frame_height", height_a, 3);
    check("frame_no_err", err_a, 0);

    // width mismatch 4,4,3 and clear
    line(4, 0);
    line(4, 1);
    line(3, 2);
    check("err_before_short_eol", err_a, 0);
    hs_start();
    check("err_after_short_eol", err_a, 1);
    check("short_width", width_a, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("err_cleared", err_a, 0);

    // timing-derived active window on u_b, DE tied low
    vsync_pulse();
    chk_b = 1'b1;
    b_line_act = 1'b1;
    b_y = 0;
    line(0, 0);
    b_y = 1;
    line(0, 0);
    b_line_act = 1'b0;
    hs_start();
    check("b_width", width_b, 3);
    blank(4);
    chk_b = 1'b0;
    vsync_pulse();
    check("b_height", height_b, 2);

    // 3-bit coordinates saturate on a 10-pixel line
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("c_err_cleared", err_c, 0);
    hs_start();
    for (int k = 0; k < 10; k++) begin
      pix(k, 0);
      check("c_valid", valid_c, 1);
      check("c_x", x_c, (k < 7) ? k : 7);
      check("c_err", err_c, (k >= 7) ? 1 : 0);
    end
    hs_start();
    blank(2);

    // reset mid-line at x=2, then a clean line
    hs_start();
    for (int k = 0; k < 3; k++) pix(k, 1);
    rst = 1'b1;
    vsync = 1'b0;
    de = 1'b1;
    tick();
    rst_check("midline_reset");
    rst = 1'b0;
    de = 1'b0;
    tick();
    tick();
    vsync = 1'b1;
    tick();
    hs_start();
    for (int k = 0; k < 4; k++) pix(k, 0);
    blank(2);
    check("post_reset_width_zero", width_a, 0);
    hs_start();
    check("post_reset_width", width_a, 4);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_sync_gen.md
Name: lcd_sync_gen

Overview:
Parametrised LCD video synchroniser for the capture path. It registers the LCD parallel bus and detects sync edges with configurable polarity. It qualifies active pixels either from DE or from porch/active timing parameters, and produces per-pixel X/Y coordinates. It also measures frame geometry (active width/height), emits start-of-frame/end-of-line strobes, and flags geometry errors to downstream framebuffer logic.

Parameters:
DATA_W, 24, pixel data width
COORD_W, 12, X/Y counter and geometry width
HS_POL, 1, hsync asserted level; line start = hsync deassertion edge
VS_POL, 0, vsync asserted level; frame start = vsync deassertion edge
USE_DE, 1, 1: active = lcd_de_i; 0: active derived from H_/V_ timing parameters
H_BP, 40, pclk cycles from line start to first active pixel (USE_DE=0)
H_ACT, 800, active pixels per line (USE_DE=0)
V_BP, 29, line starts from frame start to first active line (USE_DE=0)
V_ACT, 480, active lines per frame (USE_DE=0)

Ports:
lcd_pclk_i  in  1  pixel clock, sole clock
rst  in  1  synchronous active-high reset
lcd_data_i  in  DATA_W  pixel data
lcd_vsync_i  in  1  vertical sync
lcd_hsync_i  in  1  horizontal sync
lcd_de_i  in  1  data enable (ignored when USE_DE=0)
lcd_err_clr_i  in  1  clears lcd_geom_err_o
lcd_clk_o  out  1  lcd_pclk_i passthrough
lcd_data_o  out  DATA_W  registered pixel, 0 when not valid
lcd_data_valid_o  out  1  lcd_data_o/x/y valid
lcd_x_o  out  COORD_W  column of current valid pixel
lcd_y_o  out  COORD_W  active-line index of current valid pixel
lcd_sof_o  out  1  one-cycle pulse on frame start
lcd_eol_o  out  1  one-cycle pulse on line start following a line with >=1 active pixel
lcd_width_o  out  COORD_W  active pixel count of last completed active line
lcd_height_o  out  COORD_W  active line count of last completed frame
lcd_geom_err_o  out  1  sticky geometry error

Behaviour:
- Reset (synchronous, active-high, on lcd_pclk_i): all outputs except lcd_clk_o = 0; all counters and sync history = 0; FSMs idle. Reset mid-line discards partial line/frame; geometry remains 0 until the first full line/frame completes.
- Sync history registers: hs_q, vs_q. hs_end = (hs_q==HS_POL)&&(hsync_i!=HS_POL). vs_end likewise with VS_POL.
- Latency: exactly 1 cycle from input to lcd_data_o/valid/x/y. Strobes are registered, also 1 cycle after the detecting edge.
- Active (USE_DE=1): act = lcd_de_i.
- Active (USE_DE=0): H FSM H_IDLE->(hs_end)H_BP; H_BP counts H_BP cycles, then ->H_ACT; H_ACT asserts act for H_ACT cycles, then ->H_IDLE. V FSM V_IDLE->(vs_end)V_BP; V_BP counts V_BP hs_end events, then ->V_ACT; V_ACT counts V_ACT hs_end events, then ->V_IDLE. act = H in H_ACT && V in V_ACT. hs_end in any H state restarts H_BP. vs_end in any V state restarts V_BP. H_BP=0 makes the hs_end cycle itself the first active cycle.
- X counter x_cnt: on hs_end, x_cnt = 0 before the cycle's pixel is considered, so a pixel active in the hs_end cycle gets x=0. On act, lcd_x_o <= x_cnt and x_cnt increments, saturating at 2^COORD_W-1. A pixel arriving while saturated sets lcd_geom_err_o.
- Line flag had_act: set by any act, cleared on hs_end.
- Y counter y_cnt: on hs_end with had_act, y_cnt increments, saturating at max. On vs_end, y_cnt = 0; vs_end overrides any simultaneous increment. On act, lcd_y_o <= y_cnt.
- lcd_data_o <= act ? lcd_data_i : 0. lcd_data_valid_o <= act.
- On hs_end with had_act: lcd_eol_o pulses, and lcd_width_o <= x_cnt.
  - Error check: if the line is not the first active line of the frame and x_cnt != lcd_width_o (previous value), set lcd_geom_err_o.
- On vs_end: lcd_sof_o pulses, and lcd_height_o <= y_cnt + (hs_end && had_act ? 1 : 0).
  - Height is captured only if the frame began with an observed vs_end since reset; otherwise lcd_height_o is unchanged.
- lcd_geom_err_o: sticky. lcd_err_clr_i clears it; a set event in the same cycle as clear wins, leaving the flag at 1.
- Simultaneous hs_end+vs_end: width captured and eol pulsed; y_cnt = 0; sof pulsed.

Test Plan:
- USE_DE=1, 4x3 frame (DE 4 cycles/line, 3 lines, HS_POL=1, VS_POL=0) -> x 0..3 per line, y 0..2, eol x3, width=4, height=3 at next vsync end, err=0.
- DE low on blank lines between vsync end and first active line (5 blank hsyncs) -> y of first active line = 0, no eol on blank lines.
- Line widths 4,4,3 in one frame -> lcd_geom_err_o=1 after third eol; lcd_err_clr_i pulse -> 0 next cycle.
- USE_DE=0, H_BP=2, H_ACT=3, V_BP=1, V_ACT=2, DE tied 0 -> valid on cycles 2..4 after each hs_end on lines 1..2, width=3, height=2.
- COORD_W=3, DE held high 10 cycles -> x saturates at 7, err set.
- Assert rst mid-line with x=2 -> next cycle all outputs 0; following line restarts at x=0, geometry 0 until the first line completes.
